// File: rtl/rv32_id_ex_stage.sv
// RV32I integer-compute decode and operand-issue stage feeding rv32_alu.
// Decodes OP/OP-IMM/LUI/AUIPC, reads and forwards operands, and registers the ALU inputs.
module rv32_id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid_in,
    output logic            instr_ready_out,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            fwd_valid_in,
    input  logic [4:0]      fwd_rd_in,
    input  logic [XLEN-1:0] fwd_data_in,
    input  logic            flush_in,
    output logic [XLEN-1:0] op_1_out,
    output logic [XLEN-1:0] op_2_out,
    output logic [2:0]      funct3_out,
    output logic [3:0]      alu_opcode_out,
    output logic [4:0]      rd_out,
    output logic            reg_wr_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            illegal_out,
    output logic [31:0]     issued_count_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_shift;

    assign opcode       = instr_in[6:0];
    assign rd           = instr_in[11:7];
    assign funct3       = instr_in[14:12];
    assign funct7       = instr_in[31:25];
    assign rs1_addr_out = instr_in[19:15];
    assign rs2_addr_out = instr_in[24:20];
    assign is_shift     = (funct3 == 3'b001) || (funct3 == 3'b101);

    // x0 always reads zero; otherwise the in-flight EX result wins over the register file.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            fwd_valid,
        input logic [4:0]      fwd_rd,
        input logic [XLEN-1:0] fwd_data
    );
        if (addr == 5'd0)
            return '0;
        else if (fwd_valid && (fwd_rd == addr))
            return fwd_data;
        else
            return rf_data;
    endfunction

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = read_operand(rs1_addr_out, rs1_data_in, fwd_valid_in, fwd_rd_in, fwd_data_in);
    assign rs2_val = read_operand(rs2_addr_out, rs2_data_in, fwd_valid_in, fwd_rd_in, fwd_data_in);

    logic            dec_legal;
    logic [XLEN-1:0] dec_op_1, dec_op_2;
    logic [2:0]      dec_funct3;
    logic            dec_sub_sra;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        dec_legal   = 1'b0;
        dec_op_1    = '0;
        dec_op_2    = '0;
        dec_funct3  = funct3;
        dec_sub_sra = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op_1    = rs1_val;
                dec_op_2    = rs2_val;
                dec_sub_sra = instr_in[30];
                dec_legal   = (funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_op_1 = rs1_val;
                if (is_shift) begin
                    dec_op_2    = {{(XLEN-5){1'b0}}, instr_in[24:20]};
                    dec_sub_sra = instr_in[30];
                    dec_legal   = (funct7 == F7_BASE) ||
                                  ((funct7 == F7_ALT) && (funct3 == 3'b101));
                end else begin
                    dec_op_2  = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
                    dec_legal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_op_2   = {instr_in[31:12], 12'b0};
                dec_funct3 = 3'b000;
                dec_legal  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op_1   = pc_in;
                dec_op_2   = {instr_in[31:12], 12'b0};
                dec_funct3 = 3'b000;
                dec_legal  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] op_1_q, op_1_d;
    logic [XLEN-1:0] op_2_q, op_2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      alu_opcode_q, alu_opcode_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_wr_q, reg_wr_d;
    logic            illegal_q, illegal_d;
    logic [31:0]     issued_count_q, issued_count_d;

    logic accept, drain;
    assign instr_ready_out = !valid_q || ready_in || flush_in;
    assign accept          = instr_valid_in && instr_ready_out;
    assign drain           = valid_q && ready_in;

    always_comb begin
        valid_d        = valid_q;
        op_1_d         = op_1_q;
        op_2_d         = op_2_q;
        funct3_d       = funct3_q;
        alu_opcode_d   = alu_opcode_q;
        rd_d           = rd_q;
        reg_wr_d       = reg_wr_q;
        illegal_d      = 1'b0;
        issued_count_d = issued_count_q + 32'(drain && !flush_in);

        if (flush_in) begin
            valid_d = 1'b0;
        end else if (accept && dec_legal) begin
            valid_d      = 1'b1;
            op_1_d       = dec_op_1;
            op_2_d       = dec_op_2;
            funct3_d     = dec_funct3;
            alu_opcode_d = {dec_sub_sra, dec_funct3};
            rd_d         = rd;
            reg_wr_d     = (rd != 5'd0);
        end else if (accept) begin
            // An accept implies the old entry was empty or draining, so nothing remains valid.
            illegal_d = 1'b1;
            valid_d   = 1'b0;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all pipeline registers clear on reset; the stage holds no memory array.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q        <= 1'b0;
            op_1_q         <= '0;
            op_2_q         <= '0;
            funct3_q       <= '0;
            alu_opcode_q   <= '0;
            rd_q           <= '0;
            reg_wr_q       <= 1'b0;
            illegal_q      <= 1'b0;
            issued_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            op_1_q         <= op_1_d;
            op_2_q         <= op_2_d;
            funct3_q       <= funct3_d;
            alu_opcode_q   <= alu_opcode_d;
            rd_q           <= rd_d;
            reg_wr_q       <= reg_wr_d;
            illegal_q      <= illegal_d;
            issued_count_q <= issued_count_d;
        end
    end

    assign valid_out        = valid_q;
    assign op_1_out         = op_1_q;
    assign op_2_out         = op_2_q;
    assign funct3_out       = funct3_q;
    assign alu_opcode_out   = alu_opcode_q;
    assign rd_out           = rd_q;
    assign reg_wr_out       = reg_wr_q;
    assign illegal_out      = illegal_q;
    assign issued_count_out = issued_count_q;

endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// Self-checking bench for rv32_id_ex_stage: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level model of the stage.
module tb_rv32_id_ex_stage;

    logic        clk, rst_n;
    logic [31:0] instr, pc, rs1_data, rs2_data, fwd_data;
    logic        instr_valid, fwd_valid, flush, ready_in;
    logic [4:0]  fwd_rd;
    logic        instr_ready, reg_wr, valid, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [31:0] op_1, op_2, count;
    logic [2:0]  funct3;
    logic [3:0]  alu_opcode;

    rv32_id_ex_stage #(.XLEN(32)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .instr_in(instr), .pc_in(pc),
        .instr_valid_in(instr_valid), .instr_ready_out(instr_ready),
        .rs1_addr_out(rs1_addr), .rs2_addr_out(rs2_addr),
        .rs1_data_in(rs1_data), .rs2_data_in(rs2_data),
        .fwd_valid_in(fwd_valid), .fwd_rd_in(fwd_rd), .fwd_data_in(fwd_data),
        .flush_in(flush),
        .op_1_out(op_1), .op_2_out(op_2), .funct3_out(funct3),
        .alu_opcode_out(alu_opcode), .rd_out(rd), .reg_wr_out(reg_wr),
        .valid_out(valid), .ready_in(ready_in),
        .illegal_out(illegal), .issued_count_out(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        legal;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        reg_wr;
    } entry_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    logic   m_valid, m_illegal;
    logic [31:0] m_count;
    entry_t m_entry;

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [31:0] rf,
                                             input logic fv, input logic [4:0] frd,
                                             input logic [31:0] fd);
        if (a == 0) return 32'd0;
        if (fv && frd == a) return fd;
        return rf;
    endfunction

    // Expected issue-register contents straight from the instruction-set rules.
    function automatic entry_t ref_decode(input logic [31:0] w, input logic [31:0] p,
                                          input logic [31:0] r1, input logic [31:0] r2,
                                          input logic fv, input logic [4:0] frd,
                                          input logic [31:0] fd);
        entry_t e;
        int f3, f7, opc;
        logic [31:0] a, b;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        a   = ref_read(w[19:15], r1, fv, frd, fd);
        b   = ref_read(w[24:20], r2, fv, frd, fd);
        e = '0;
        e.rd     = w[11:7];
        e.reg_wr = (w[11:7] != 0);
        if (opc == 'h33) begin
            e.legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.op1 = a; e.op2 = b; e.alu = {w[30], w[14:12]};
        end else if (opc == 'h13 && (f3 == 1 || f3 == 5)) begin
            e.legal = (f7 == 0) || (f7 == 'h20 && f3 == 5);
            e.op1 = a; e.op2 = 32'(w[24:20]); e.alu = {w[30], w[14:12]};
        end else if (opc == 'h13) begin
            e.legal = 1'b1;
            e.op1 = a; e.op2 = 32'($signed(w[31:20])); e.alu = {1'b0, w[14:12]};
        end else if (opc == 'h37 || opc == 'h17) begin
            e.legal = 1'b1;
            e.op1 = (opc == 'h17) ? p : 32'd0;
            e.op2 = w & 32'hFFFF_F000;
            e.alu = 4'd0;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_illegal = 0; m_count = 0; m_entry = '0;
    endtask

    // Advance the model by one edge from the inputs currently driven, then step the clock.
    task automatic tick();
        logic   rdy, acc;
        entry_t d;
        rdy = !m_valid || ready_in || flush;
        acc = instr_valid && rdy;
        d   = ref_decode(instr, pc, rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data);
        if (m_valid && ready_in && !flush) m_count++;
        if (flush) begin
            m_valid = 0; m_illegal = 0;
        end else if (acc && d.legal) begin
            m_entry = d; m_valid = 1; m_illegal = 0;
        end else if (acc) begin
            m_valid = 0; m_illegal = 1;
        end else begin
            m_illegal = 0;
            if (m_valid && ready_in) m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 0; flush = 0; ready_in = 1; fwd_valid = 0; fwd_rd = 0;
        fwd_data = 0; pc = 0; rs1_data = 0; rs2_data = 0; instr = 32'h0000_0013;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        n_tests++;
        if ({valid, op_1, op_2, funct3, alu_opcode, rd, reg_wr, illegal, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b op1=%h op2=%h alu=%h rd=%0d wr=%0b ill=%0b cnt=%0d, all required 0",
                     valid, op_1, op_2, alu_opcode, rd, reg_wr, illegal, count);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        instr = 32'h0050_0293; instr_valid = 1; rs1_data = 32'h1234; tick();
        instr_valid = 0;
        n_tests++;
        if ({op_1, op_2, alu_opcode, rd, reg_wr, valid} !== {32'd0, 32'd5, 4'b0000, 5'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL addi: op1=%h op2=%h alu=%b rd=%0d wr=%0b v=%0b, required 0 5 0000 5 1 1",
                     op_1, op_2, alu_opcode, rd, reg_wr, valid);
        end
        tick();
        n_tests++;
        if ({valid, count} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL addi_drain: valid=%0b count=%0d, required 0 1", valid, count);
        end
    endtask

    task automatic test_sub_srai();
        instr = 32'h4020_81B3; instr_valid = 1; rs1_data = 5; rs2_data = 3; tick();
        n_tests++;
        if ({op_1, op_2, alu_opcode, rd, funct3} !== {32'd5, 32'd3, 4'b1000, 5'd3, 3'b000}) begin
            n_fail++;
            $display("FAIL sub: op1=%h op2=%h alu=%b rd=%0d, required 5 3 1000 3", op_1, op_2, alu_opcode, rd);
        end
        instr = 32'h4010_D093; rs1_data = 32'h8000_0000; tick();
        instr_valid = 0;
        n_tests++;
        if ({op_1, op_2, alu_opcode, funct3, valid, count} !==
            {32'h8000_0000, 32'd1, 4'b1101, 3'b101, 1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL srai_back_to_back: op1=%h op2=%h alu=%b v=%0b cnt=%0d, required 80000000 1 1101 1 2",
                     op_1, op_2, alu_opcode, valid, count);
        end
        tick();
    endtask

    task automatic test_lui_auipc();
        instr = 32'h1234_52B7; instr_valid = 1; rs1_data = 32'hFFFF_FFFF; tick();
        n_tests++;
        if ({op_1, op_2, alu_opcode, rd} !== {32'd0, 32'h1234_5000, 4'd0, 5'd5}) begin
            n_fail++;
            $display("FAIL lui: op1=%h op2=%h alu=%b rd=%0d, required 0 12345000 0000 5", op_1, op_2, alu_opcode, rd);
        end
        instr = 32'h1234_5297; pc = 32'h100; tick();
        instr_valid = 0;
        n_tests++;
        if ({op_1, op_2, alu_opcode, rd} !== {32'h100, 32'h1234_5000, 4'd0, 5'd5}) begin
            n_fail++;
            $display("FAIL auipc: op1=%h op2=%h alu=%b rd=%0d, required 100 12345000 0000 5", op_1, op_2, alu_opcode, rd);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] cnt0;
        instr = 32'h0050_0293; instr_valid = 1; tick();
        cnt0 = m_count;
        instr = 32'h1234_52B7; ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (instr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: instr_ready=%0b, required 0", i, instr_ready);
            end
            tick();
            n_tests++;
            if ({valid, op_1, op_2, rd, count} !== {1'b1, 32'd0, 32'd5, 5'd5, cnt0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%0b op2=%h rd=%0d cnt=%0d, required 1 5 5 %0d",
                         i, valid, op_2, rd, count, cnt0);
            end
        end
        ready_in = 1; #1;
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: instr_ready=%0b, required 1", instr_ready);
        end
        tick();
        instr_valid = 0;
        n_tests++;
        if ({valid, op_2, count} !== {1'b1, 32'h1234_5000, cnt0 + 32'd1}) begin
            n_fail++;
            $display("FAIL release_replace: v=%0b op2=%h cnt=%0d, required 1 12345000 %0d",
                     valid, op_2, count, cnt0 + 1);
        end
        tick();
    endtask

    task automatic test_forwarding();
        instr = 32'h4020_81B3; instr_valid = 1; rs1_data = 5; rs2_data = 3;
        fwd_valid = 1; fwd_rd = 1; fwd_data = 32'hDEAD_BEEF; #1;
        n_tests++;
        if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin
            n_fail++;
            $display("FAIL rs_addr: rs1=%0d rs2=%0d, required 1 2", rs1_addr, rs2_addr);
        end
        tick();
        n_tests++;
        if ({op_1, op_2} !== {32'hDEAD_BEEF, 32'd3}) begin
            n_fail++;
            $display("FAIL fwd_rs1: op1=%h op2=%h, required deadbeef 3", op_1, op_2);
        end
        instr = 32'h0050_0293; fwd_rd = 0; rs1_data = 7; tick();
        instr_valid = 0; fwd_valid = 0;
        n_tests++;
        if (op_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL fwd_x0: op1=%h, required 0", op_1);
        end
        tick();
    endtask

    task automatic test_illegal_flush();
        logic [31:0] cnt0;
        cnt0 = m_count;
        instr = 32'h0220_81B3; instr_valid = 1; tick();
        instr_valid = 0;
        n_tests++;
        if ({illegal, valid, count} !== {1'b1, 1'b0, cnt0}) begin
            n_fail++;
            $display("FAIL illegal_mul: ill=%0b v=%0b cnt=%0d, required 1 0 %0d", illegal, valid, count, cnt0);
        end
        tick();
        n_tests++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: ill=%0b, required 0", illegal);
        end
        instr = 32'h0050_0293; instr_valid = 1; tick();
        ready_in = 0; instr = 32'h1234_52B7; tick();
        flush = 1; tick();
        flush = 0; instr_valid = 0;
        n_tests++;
        if ({valid, illegal, count} !== {1'b0, 1'b0, cnt0}) begin
            n_fail++;
            $display("FAIL flush_stall: v=%0b ill=%0b cnt=%0d, required 0 0 %0d", valid, illegal, count, cnt0);
        end
        ready_in = 1; tick();
        n_tests++;
        if ({valid, count} !== {1'b0, cnt0}) begin
            n_fail++;
            $display("FAIL flush_discard: v=%0b cnt=%0d, required 0 %0d", valid, count, cnt0);
        end
    endtask

    task automatic test_reset_mid_run();
        instr = 32'h1234_5297; pc = 32'h40; instr_valid = 1; tick();
        ready_in = 0; instr_valid = 0; tick();
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({valid, op_1, op_2, funct3, alu_opcode, rd, reg_wr, illegal, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: v=%0b op1=%h op2=%h rd=%0d cnt=%0d, all required 0",
                     valid, op_1, op_2, rd, count);
        end
        model_reset();
        idle_inputs();
        #1 rst_n = 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7s [4];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w = {f7s[$urandom_range(0, 3)], w[24:7], 7'h33};
            1: w = {f7s[$urandom_range(0, 2)], w[24:7], 7'h13};
            2: w = {w[31:7], 7'h13};
            3: w = {w[31:7], 7'h37};
            4: w = {w[31:7], 7'h17};
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            instr       = rand_instr();
            pc          = $urandom;
            rs1_data    = $urandom;
            rs2_data    = $urandom;
            instr_valid = ($urandom_range(0, 3) != 0);
            ready_in    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            fwd_valid   = $urandom_range(0, 1);
            fwd_rd      = $urandom_range(0, 1) ? instr[19:15] : 5'($urandom);
            fwd_data    = $urandom;
            #1;
            n_tests++;
            if ({instr_ready, rs1_addr, rs2_addr} !==
                {(!m_valid || ready_in || flush), instr[19:15], instr[24:20]}) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: ready=%0b rs1=%0d rs2=%0d", i, instr_ready, rs1_addr, rs2_addr);
            end
            tick();
            n_tests++;
            if ({valid, illegal, count} !== {m_valid, m_illegal, m_count}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: v=%0b ill=%0b cnt=%0d, required %0b %0b %0d",
                         i, valid, illegal, count, m_valid, m_illegal, m_count);
            end
            if (m_valid) begin
                n_tests++;
                if ({op_1, op_2, alu_opcode, funct3, rd, reg_wr} !==
                    {m_entry.op1, m_entry.op2, m_entry.alu, m_entry.alu[2:0], m_entry.rd, m_entry.reg_wr}) begin
                    n_fail++;
                    $display("FAIL rand_entry[%0d]: op1=%h op2=%h alu=%b rd=%0d wr=%0b, required %h %h %b %0d %0b",
                             i, op_1, op_2, alu_opcode, rd, reg_wr,
                             m_entry.op1, m_entry.op2, m_entry.alu, m_entry.rd, m_entry.reg_wr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_srai();
        test_lui_auipc();
        test_backpressure();
        test_forwarding();
        test_illegal_flush();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_id_ex_stage.md
# rv32_id_ex_stage

Decode and operand-issue stage directly upstream of `rv32_alu`. It accepts a fetched instruction and PC, decodes the RV32I integer-compute subset, reads operands from the register file, applies EX-stage forwarding, and registers the ALU inputs `op_1`, `op_2`, `funct3` and the 4-bit ALU opcode behind a valid/ready pipeline register. It also counts issued instructions.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `instr_in`  in  32  instruction word.
- `pc_in`  in  32  PC of `instr_in`.
- `instr_valid_in`  in  1  upstream valid.
- `instr_ready_out`  out  1  upstream ready, combinational.
- `rs1_addr_out`, `rs2_addr_out`  out  5  combinational register-file read addresses, equal to `instr_in[19:15]` and `instr_in[24:20]`.
- `rs1_data_in`, `rs2_data_in`  in  32  combinational register-file read data.
- `fwd_valid_in`  in  1  EX result is valid for forwarding.
- `fwd_rd_in`  in  5  EX destination register.
- `fwd_data_in`  in  32  EX result.
- `flush_in`  in  1  kill the stage contents.
- `op_1_out`, `op_2_out`  out  32  registered ALU operands.
- `funct3_out`  out  3  registered funct3.
- `alu_opcode_out`  out  4  registered ALU opcode, `{sub_sra, funct3}`.
- `rd_out`  out  5  destination register.
- `reg_wr_out`  out  1  writeback enable.
- `valid_out`  out  1  downstream valid.
- `ready_in`  in  1  downstream ready.
- `illegal_out`  out  1  one-cycle pulse when an illegal instruction is accepted.
- `issued_count_out`  out  32  count of downstream handshakes.

## Operation
**Handshake**
- `instr_ready_out = !valid_out || ready_in || flush_in`.
- An instruction is accepted when `instr_valid_in && instr_ready_out`.

**Decode**, by `opcode = instr[6:0]`:
- OP (`0110011`)
  - `op_1` = rs1, `op_2` = rs2.
  - funct7 must be `0000000`; `0100000` is legal only when funct3 is 000 or 101.
  - `sub_sra` = `instr[30]`.
- OP-IMM (`0010011`)
  - `op_1` = rs1, `op_2` = sign-extended `instr[31:20]`.
  - For funct3 001 or 101: `op_2 = {27'b0, instr[24:20]}` and `sub_sra = instr[30]`.
  - Legal shift funct7 is `0000000` for 001 and 101, or `0100000` for 101 only.
  - For all other funct3: `sub_sra` = 0.
- LUI (`0110111`): `op_1` = 0, `op_2` = `{instr[31:12], 12'b0}`, funct3 = 000, `sub_sra` = 0.
- AUIPC (`0010111`): `op_1` = `pc_in`, `op_2` = `{instr[31:12], 12'b0}`, funct3 = 000, `sub_sra` = 0.
- Any other opcode or funct7 (including M-extension `0000001`) is illegal.
- `funct3_out` = `instr[14:12]` for OP and OP-IMM.

**Operand read**
- Register 0 reads as 0 regardless of `rs*_data_in`.
- Otherwise, if `fwd_valid_in && fwd_rd_in == addr`, use `fwd_data_in`; else use `rs*_data_in`.

**Register load**
- On accept of a legal instruction, load all outputs and set `valid_out` = 1.
- `reg_wr_out` = (`rd` != 0).

**Illegal instruction**
- An accepted illegal instruction is consumed and dropped.
- `illegal_out` = 1 for the next cycle only.
- `valid_out` goes to 0 if the current entry also drains that cycle.

**Drain and hold**
- With no accept and `valid_out && ready_in`: `valid_out` goes to 0.
- While `valid_out && !ready_in`: all outputs hold stable.

**Flush**
- `flush_in` has priority over everything else.
- Next cycle `valid_out` = 0 and `illegal_out` = 0.
- Any instruction accepted in the flush cycle is discarded.
- `issued_count_out` does not increment for an entry that is flushed without its handshake.

**Counter**
- `issued_count_out` increments on `valid_out && ready_in && !flush_in`.
- Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: every output register clears to 0 asynchronously (`valid_out`, operands, funct3, opcode, `rd_out`, `reg_wr_out`, `illegal_out`, counter).
- Latency: accept at edge N gives `valid_out` = 1 after edge N. One instruction per cycle at full throughput when `ready_in` is held 1.
- Simultaneous drain and accept: the register is replaced with the new entry; `valid_out` stays 1 and the counter increments.
- Reset asserted mid-stall: the held entry is lost with no handshake.
- `rs*_addr_out` are combinational from `instr_in`. Register-file read and forwarding are sampled at the accept edge.

## Test plan
1. ADDI `0x00500293` accepted with `ready_in` = 1 → next cycle:
   - `op_1` = 0, `op_2` = 5, `alu_opcode` = 0000
   - `rd` = 5, `reg_wr` = 1, `valid_out` = 1
2. SUB `0x402081B3` with rs1_data = 5, rs2_data = 3 → `op_1` = 5, `op_2` = 3, `alu_opcode` = 1000, `rd` = 3. Also SRAI `0x4010D093` with rs1_data = 0x80000000 → `op_2` = 1, `alu_opcode` = 1101.
3. LUI `0x123452B7` → `op_1` = 0, `op_2` = 0x12345000, `rd` = 5. AUIPC `0x12345297` with pc = 0x100 → `op_1` = 0x100, `op_2` = 0x12345000.
4. Backpressure: `ready_in` = 0 for 3 cycles with `valid_out` = 1 → `instr_ready_out` = 0 and outputs stable. Then `ready_in` = 1 → counter +1 and the next instruction loads on the same edge.
5. Forwarding with `fwd_valid_in` = 1, `fwd_rd_in` = 1, data 0xDEADBEEF, rs1_data = 5, instr SUB above → `op_1` = 0xDEADBEEF. With `fwd_rd_in` = 0 and rs1 = x0 → `op_1` = 0.
6. Illegal MUL `0x022081B3` → `illegal_out` pulses for 1 cycle, `valid_out` = 0, counter unchanged. Flush during a stall → `valid_out` = 0 next cycle, counter unchanged. Reset mid-run → all outputs 0 immediately.
